// File: rtl/xy_dac_spi_driver.sv
// Snapshots X/Y beam coordinates each frame and streams them to a dual-channel
// 12-bit SPI DAC (channel A = X, channel B = Y), then strobes LDAC for a joint update.
module xy_dac_spi_driver #(
    parameter int OUT_WIDTH   = 8,
    parameter int SCLK_DIV    = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int LDAC_CYCLES = 2,
    parameter int GAIN_2X     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [OUT_WIDTH-1:0] x_in,
    input  logic [OUT_WIDTH-1:0] y_in,
    output logic                 dac_cs_n,
    output logic                 dac_sclk,
    output logic                 dac_mosi,
    output logic                 dac_ldac_n,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_MAX = (GAP_CYCLES > LDAC_CYCLES) ? GAP_CYCLES : LDAC_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV + 1) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic             GAIN_BIT  = (GAIN_2X != 0) ? 1'b0 : 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_A,
        GAP_A,
        SHIFT_B,
        GAP_B,
        LATCH
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           bit_q, bit_d;
    logic [14:0]          sreg_q, sreg_d;
    logic [OUT_WIDTH-1:0] x_q, x_d;
    logic [OUT_WIDTH-1:0] y_q, y_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 ldac_n_q, ldac_n_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic [15:0]          word_a;
    logic [15:0]          word_b;

    function automatic logic [15:0] build_word(input logic chan, input logic [OUT_WIDTH-1:0] coord);
        logic [11:0] field;
        field = 12'(coord);
        field = field << (12 - OUT_WIDTH);
        return {chan, 1'b0, GAIN_BIT, 1'b1, field};
    endfunction

    assign word_a = build_word(1'b0, x_q);
    assign word_b = build_word(1'b1, y_q);

    // Outputs are computed for the next state so each registered output lines up
    // with the state it belongs to; the MSB goes straight to mosi, the rest waits in sreg.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        bit_d        = bit_q;
        sreg_d       = sreg_q;
        x_d          = x_q;
        y_d          = y_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        ldac_n_d     = ldac_n_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                    x_d     = x_in;
                    y_d     = y_in;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d = SHIFT_A;
                div_d   = '0;
                bit_d   = '0;
                sreg_d  = word_a[14:0];
                mosi_d  = word_a[15];
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
            end
            SHIFT_A, SHIFT_B: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = (state_q == SHIFT_A) ? GAP_A : GAP_B;
                        end else begin
                            bit_d  = bit_q + 4'd1;
                            mosi_d = sreg_q[14];
                            sreg_d = {sreg_q[13:0], 1'b0};
                        end
                    end
                end
            end
            GAP_A: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = SHIFT_B;
                    div_d   = '0;
                    bit_d   = '0;
                    sreg_d  = word_b[14:0];
                    mosi_d  = word_b[15];
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP_B: begin
                if (cnt_q == GAP_LAST) begin
                    state_d  = LATCH;
                    cnt_d    = '0;
                    ldac_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == LDAC_LAST) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    ldac_n_d     = 1'b1;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            sreg_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            ldac_n_q     <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            sreg_q       <= sreg_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            ldac_n_q     <= ldac_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;
    assign dac_ldac_n = ldac_n_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
